// File: rtl/display_page_scanner.sv
// Time-multiplexed 7-seg digit scanner: walks the digit strobes, picks the nibble of the
// current page, and applies frame-aligned page switching, blink and leading-zero blanking.
module display_page_scanner #(
  parameter int DIGITS       = 4,
  parameter int PAGES        = 4,
  parameter int SCAN_DIV     = 50000,
  parameter int BLINK_FRAMES = 64,
  parameter int PW           = (PAGES > 1) ? $clog2(PAGES) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [PAGES*DIGITS*4-1:0] data_in,
  input  logic [PW-1:0]             page_sel,
  input  logic [DIGITS-1:0]         blink_mask,
  input  logic                      blank_lz,
  output logic [DIGITS-1:0]         an,
  output logic [3:0]                hex_out,
  output logic                      digit_blank,
  output logic                      frame_done
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DW = $clog2(DIGITS);
  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [PW:0] PAGES_W = (PW+1)'(PAGES);

  logic [CW-1:0]       div_cnt;
  logic [DW-1:0]       digit_idx;
  logic [PW-1:0]       page_reg;
  logic [BW-1:0]       blink_cnt;
  logic                blink_phase;

  logic                tick;
  logic                last_digit;
  logic                frame_edge;
  logic [DW-1:0]       nidx;
  logic                page_ok;
  logic [PW-1:0]       page_eff;
  logic                blink_wrap;
  logic                phase_next;
  logic [DIGITS*4-1:0] page_word;
  logic [3:0]          nib_sel;
  logic                lz_hit;
  logic                blink_hit;
  logic                lz_off;

  assign tick       = (div_cnt == CW'(SCAN_DIV - 1));
  assign last_digit = (digit_idx == DW'(DIGITS - 1));
  assign frame_edge = tick & last_digit;
  assign nidx       = last_digit ? '0 : digit_idx + DW'(1);

  // The new page and blink phase take effect on the boundary edge itself, so digit 0
  // of the new frame already reflects them and a frame is never torn.
  assign page_ok    = ({1'b0, page_sel} < PAGES_W);
  assign page_eff   = (frame_edge && page_ok) ? page_sel : page_reg;
  assign blink_wrap = (blink_cnt == BW'(BLINK_FRAMES - 1));
  assign phase_next = (frame_edge && blink_wrap) ? ~blink_phase : blink_phase;

  always_comb begin
    page_word = '0;
    for (int p = 0; p < PAGES; p++) begin
      if (PW'(p) == page_eff) page_word = data_in[p*DIGITS*4 +: DIGITS*4];
    end
  end

  // lz_hit: the selected digit and every more-significant digit of the page are zero.
  always_comb begin
    nib_sel   = '0;
    lz_hit    = 1'b0;
    blink_hit = 1'b0;
    for (int d = 0; d < DIGITS; d++) begin
      if (DW'(d) == nidx) begin
        nib_sel   = page_word[d*4 +: 4];
        blink_hit = blink_mask[d];
        lz_hit    = 1'b1;
        for (int j = 0; j < DIGITS; j++) begin
          if (j >= d && page_word[j*4 +: 4] != 4'h0) lz_hit = 1'b0;
        end
      end
    end
  end

  assign lz_off = blank_lz & (nidx != '0) & lz_hit;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt     <= '0;
      digit_idx   <= '0;
      page_reg    <= '0;
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
      an          <= {{(DIGITS-1){1'b1}}, 1'b0};
      hex_out     <= 4'h0;
      digit_blank <= 1'b1;
      frame_done  <= 1'b0;
    end else begin
      frame_done <= frame_edge;
      div_cnt    <= tick ? '0 : div_cnt + CW'(1);
      if (tick) begin
        digit_idx   <= nidx;
        an          <= ~(DIGITS'(1) << nidx);
        hex_out     <= nib_sel;
        digit_blank <= (phase_next & blink_hit) | lz_off;
      end
      if (frame_edge) begin
        page_reg    <= page_eff;
        blink_cnt   <= blink_wrap ? '0 : blink_cnt + BW'(1);
        blink_phase <= phase_next;
      end
    end
  end

endmodule
